// File: rtl/if_pc_fetch.sv
// Instruction-fetch front end: PC register, single-outstanding imem requests, IF/ID delivery with a one-entry skid buffer.
// Optional build macro IF_MISALIGN_TRAP_EN: misaligned redirects trap to TRAP_VECTOR and pulse misalign_fault.
module if_pc_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        misalign_fault
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        skid_valid_q, skid_valid_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        fault_q, fault_d;
  logic [31:0] req_addr_q;
  logic [31:0] skid_pc_q;
  logic [31:0] skid_instr_q;

  logic        grant;
  logic        resp;
  logic        resp_live;
  logic        accept;
  logic        trap_sel;
  logic [31:0] redirect_pc;

`ifdef IF_MISALIGN_TRAP_EN
  assign trap_sel = |jump_target[1:0];
`else
  logic unused_tgt_lsb;
  assign trap_sel       = 1'b0;
  assign unused_tgt_lsb = ^jump_target[1:0];
`endif

  assign imem_req    = (state_q == S_REQ) && !skid_valid_q;
  assign imem_addr   = pc_q;
  assign grant       = imem_req && imem_gnt;
  // rvalid outside S_WAIT belongs to a request lost across reset and is ignored
  assign resp        = (state_q == S_WAIT) && imem_rvalid;
  assign resp_live   = resp && !kill_q;
  assign accept      = redirect_valid && !stall;
  assign redirect_pc = trap_sel ? TRAP_VECTOR : {jump_target[31:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    skid_valid_d = skid_valid_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    fault_d      = 1'b0;

    case (state_q)
      S_BOOT:  state_d = S_REQ;
      S_REQ: begin
        if (grant) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_WAIT;
        end
      end
      S_WAIT:  if (imem_rvalid) state_d = S_REQ;
      default: state_d = S_BOOT;
    endcase

    if (resp && kill_q) kill_d = 1'b0;

    if (!stall) begin
      if (skid_valid_q) begin
        if_valid_d   = 1'b1;
        if_pc_d      = skid_pc_q;
        if_instr_d   = skid_instr_q;
        skid_valid_d = 1'b0;
      end else if (resp_live) begin
        if_valid_d = 1'b1;
        if_pc_d    = req_addr_q;
        if_instr_d = imem_rdata;
      end else begin
        if_valid_d = 1'b0;
      end
    end else if (resp_live) begin
      skid_valid_d = 1'b1;
    end

    // A redirect squashes delivery and marks any in-flight request for dropping
    if (accept) begin
      pc_d         = redirect_pc;
      fault_d      = trap_sel;
      if_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
      kill_d       = grant || ((state_q == S_WAIT) && !imem_rvalid);
      state_d      = kill_d ? S_WAIT : S_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_VECTOR;
      kill_q       <= 1'b0;
      skid_valid_q <= 1'b0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= 32'd0;
      if_instr_q   <= 32'd0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      skid_valid_q <= skid_valid_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      fault_q      <= fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) req_addr_q <= pc_q;
    if (stall && resp_live) begin
      skid_pc_q    <= req_addr_q;
      skid_instr_q <= imem_rdata;
    end
  end

  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;
  assign misalign_fault = fault_q;

endmodule

// File: tb/tb_if_pc_fetch.sv
// Directed bench for if_pc_fetch with a small latency-programmable instruction memory (rdata = ~addr).
module tb_if_pc_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        misalign_fault;

  int unsigned lat;
  int unsigned cnt;
  int          n_vec;
  int          n_miss;

  logic [31:0] exp_tgt;
  logic        exp_fault;

  if_pc_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .jump_target    (jump_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .misalign_fault (misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory grants immediately and returns data lat cycles after the grant
  assign imem_gnt = imem_req;
  always @(posedge clk) begin
    imem_rvalid <= 1'b0;
    if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) imem_rvalid <= 1'b1;
    end
    if (imem_req && imem_gnt) begin
      imem_rdata <= ~imem_addr;
      if (lat <= 1) imem_rvalid <= 1'b1;
      else cnt <= lat - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    lat = 1; cnt = 0;
    imem_rvalid = 1'b0; imem_rdata = 32'd0;
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; jump_target = 32'd0;
`ifdef IF_MISALIGN_TRAP_EN
    exp_tgt = 32'h0000_0100; exp_fault = 1'b1;
`else
    exp_tgt = 32'h0000_0400; exp_fault = 1'b0;
`endif

    tick(); tick();
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_fault", {31'd0, misalign_fault}, 32'd0);

    // Boot and sequential fetch
    rst_n = 1'b1;
    tick();
    chk("boot_req", {31'd0, imem_req}, 32'd1);
    chk("boot_addr", imem_addr, 32'h0);
    tick();
    chk("wait_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    chk("d0_valid", {31'd0, if_valid}, 32'd1);
    chk("d0_pc", if_pc, 32'h0);
    chk("d0_instr", if_instr, 32'hFFFF_FFFF);
    chk("req4_addr", imem_addr, 32'h4);
    tick();
    chk("gap_valid", {31'd0, if_valid}, 32'd0);
    tick();
    chk("d1_pc", if_pc, 32'h4);
    chk("d1_instr", if_instr, 32'hFFFF_FFFB);
    chk("req8_addr", imem_addr, 32'h8);

    // Stall while 0x8 is outstanding: word goes to skid buffer
    tick();
    stall = 1'b1;
    tick();
    chk("skid_noreq", {31'd0, imem_req}, 32'd0);
    chk("skid_hold_pc", if_pc, 32'h4);
    tick();
    chk("skid_noreq2", {31'd0, imem_req}, 32'd0);
    chk("skid_hold_pc2", if_pc, 32'h4);
    stall = 1'b0;
    tick();
    chk("skid_valid", {31'd0, if_valid}, 32'd1);
    chk("skid_pc", if_pc, 32'h8);
    chk("skid_instr", if_instr, 32'hFFFF_FFF7);
    chk("reqC_req", {31'd0, imem_req}, 32'd1);
    chk("reqC_addr", imem_addr, 32'hC);
    tick(); tick();
    chk("dC_pc", if_pc, 32'hC);
    chk("dC_instr", if_instr, 32'hFFFF_FFF3);

    // Redirect to 0x400 while fetch of 0x10 is outstanding
    lat = 2;
    tick();
    redirect_valid = 1'b1; jump_target = 32'h0000_0400;
    tick();
    redirect_valid = 1'b0; lat = 1;
    chk("redir_valid0", {31'd0, if_valid}, 32'd0);
    chk("redir_wait", {31'd0, imem_req}, 32'd0);
    tick();
    chk("kill_drop", {31'd0, if_valid}, 32'd0);
    chk("redir_req", {31'd0, imem_req}, 32'd1);
    chk("redir_addr", imem_addr, 32'h400);
    tick(); tick();
    chk("d400_valid", {31'd0, if_valid}, 32'd1);
    chk("d400_pc", if_pc, 32'h400);
    chk("d400_instr", if_instr, 32'hFFFF_FBFF);
    chk("req404_addr", imem_addr, 32'h404);

    // Redirect under stall is ignored
    stall = 1'b1; redirect_valid = 1'b1; jump_target = 32'h0000_0200;
    tick();
    stall = 1'b0; redirect_valid = 1'b0;
    chk("stall_hold_valid", {31'd0, if_valid}, 32'd1);
    chk("stall_hold_pc", if_pc, 32'h400);
    tick();
    chk("d404_pc", if_pc, 32'h404);
    chk("seq_req", {31'd0, imem_req}, 32'd1);
    chk("seq_addr", imem_addr, 32'h408);

    // Misaligned redirect, issued in the same cycle as a grant
    redirect_valid = 1'b1; jump_target = 32'h0000_0402;
    tick();
    redirect_valid = 1'b0;
    chk("mis_fault", {31'd0, misalign_fault}, {31'd0, exp_fault});
    chk("mis_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    chk("mis_fault_end", {31'd0, misalign_fault}, 32'd0);
    chk("mis_drop", {31'd0, if_valid}, 32'd0);
    chk("mis_req", {31'd0, imem_req}, 32'd1);
    chk("mis_addr", imem_addr, exp_tgt);
    tick(); tick();
    chk("mis_d_pc", if_pc, exp_tgt);
    chk("mis_d_instr", if_instr, ~exp_tgt);

    // Reset while waiting; the late rvalid must be ignored
    lat = 2;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rw_valid", {31'd0, if_valid}, 32'd0);
    chk("rw_pc", if_pc, 32'd0);
    chk("rw_req", {31'd0, imem_req}, 32'd0);
    tick();
    lat = 1;
    chk("late_valid", {31'd0, if_valid}, 32'd0);
    chk("late_pc", if_pc, 32'd0);
    chk("late_instr", if_instr, 32'd0);
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0);
    tick(); tick();
    chk("restart_valid", {31'd0, if_valid}, 32'd1);
    chk("restart_pc", if_pc, 32'h0);
    chk("restart_instr", if_instr, 32'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
